// File: rtl/uart_reg_responder.sv
// Byte-command responder behind a UART: 'R' addr / 'W' addr data commands drive a
// small register bus and return one reply byte (data, ACK or NAK) per command.
module uart_reg_responder #(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_BITS   = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  output logic [7:0]            tx_data,
  output logic                  tx_en,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  output logic                  timeout,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, READ, LATCH, SEND, WAIT_DONE
  } state_t;

  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  localparam logic [TIMEOUT_BITS-1:0] TO_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic                    is_read;
  logic [TIMEOUT_BITS-1:0] tcnt;
  logic                    addr_bad;
  logic                    busy_state;

  assign addr_bad   = (rx_data >> ADDR_WIDTH) != 8'd0;
  assign busy_state = (state == READ) || (state == LATCH) ||
                      (state == SEND) || (state == WAIT_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_read   <= 1'b0;
      tcnt      <= '0;
      tx_data   <= 8'h00;
      tx_en     <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      tx_en   <= 1'b0;
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      timeout <= 1'b0;
      overrun <= rx_done && busy_state;
      case (state)
        IDLE: if (rx_done) begin
          tcnt <= '0;
          if (rx_data == CMD_R || rx_data == CMD_W) begin
            is_read <= (rx_data == CMD_R);
            state   <= GET_ADDR;
          end else begin
            tx_data <= NAK;
            state   <= SEND;
          end
        end
        GET_ADDR: begin
          if (rx_done) begin
            tcnt <= '0;
            if (addr_bad) begin
              tx_data <= NAK;
              state   <= SEND;
            end else begin
              reg_addr <= rx_data[ADDR_WIDTH-1:0];
              // reg_re is high during the READ cycle so rdata lands in LATCH
              if (is_read) begin
                reg_re <= 1'b1;
                state  <= READ;
              end else begin
                state  <= GET_DATA;
              end
            end
          end else if (tcnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GET_DATA: begin
          if (rx_done) begin
            tcnt      <= '0;
            reg_wdata <= rx_data;
            reg_we    <= 1'b1;
            tx_data   <= ACK;
            state     <= SEND;
          end else if (tcnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        READ:  state <= LATCH;
        LATCH: begin
          tx_data <= reg_rdata;
          state   <= SEND;
        end
        SEND: if (!tx_busy) begin
          tx_en <= 1'b1;
          state <= WAIT_DONE;
        end
        WAIT_DONE: if (tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench: stimulus pushes expected replies/strobes, a negedge monitor pops and compares.
module tb_uart_reg_responder;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          tx_busy;
  logic          tx_done;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata;
  logic          timeout;
  logic          overrun;

  logic       m_busy;
  logic [3:0] m_cnt;
  logic       hold_busy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int seen_to = 0, exp_to = 0, seen_ov = 0, exp_ov = 0;
  logic [7:0]  exp_tx[$];
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];

  uart_reg_responder #(.ADDR_WIDTH(AW), .TIMEOUT_BITS(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy), .tx_done(tx_done),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .timeout(timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Transmitter: busy for a few cycles after tx_en, then a tx_done pulse.
  assign tx_busy = m_busy | hold_busy;
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 4'd0; tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 4'd0) begin m_busy <= 1'b0; tx_done <= 1'b1; end
        else m_cnt <= m_cnt - 4'd1;
      end else if (tx_en) begin
        m_busy <= 1'b1; m_cnt <= 4'd5;
      end
    end
  end

  // Register file: fixed contents 0x59 ^ addr, data one cycle after reg_re.
  always @(posedge clk)
    reg_rdata <= reg_re ? (8'h59 ^ {4'h0, reg_addr}) : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_en) begin
          chk("tx_en single pulse", {31'd0, prev_en}, 32'd0);
          if (exp_tx.size() == 0) chk("unexpected tx_en", 32'd1, 32'd0);
          else chk("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
        end
        if (reg_we) begin
          chk("we/re exclusive", {31'd0, reg_re}, 32'd0);
          if (exp_wr.size() == 0) chk("unexpected reg_we", 32'd1, 32'd0);
          else chk("write addr/data", {20'd0, reg_addr, reg_wdata}, {20'd0, exp_wr.pop_front()});
        end
        if (reg_re) begin
          if (exp_rd.size() == 0) chk("unexpected reg_re", 32'd1, 32'd0);
          else chk("read addr", {28'd0, reg_addr}, {28'd0, exp_rd.pop_front()});
        end
        if (timeout) seen_to++;
        if (overrun) seen_ov++;
      end
      prev_en = tx_en;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
  endtask

  task automatic tx_latency(input string name, input int exp);
    int n;
    n = 0;
    while (!tx_en && n < 60) begin @(negedge clk); n++; end
    chk(name, n, exp);
  endtask

  task automatic wait_tx_done();
    int n;
    n = 0;
    while (!tx_done && n < 100) begin @(negedge clk); n++; end
    if (!tx_done) chk("tx_done timeout", 32'd0, 32'd1);
  endtask

  task automatic check_zero(input string name);
    chk(name, {tx_en, tx_data, reg_addr, reg_wdata, reg_we, reg_re, timeout, overrun}, 32'd0);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d}); exp_tx.push_back(8'h06);
    send_byte(8'h57); send_byte({4'h0, a}); send_byte(d);
    tx_latency("write latency", 1);
    wait_tx_done();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] d);
    exp_rd.push_back(a); exp_tx.push_back(d);
    send_byte(8'h52); send_byte({4'h0, a});
    tx_latency("read latency", 3);
    wait_tx_done();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_zero("reset outputs");
    rst = 1'b0;

    do_write(4'h3, 8'hA5);
    do_read(4'h3, 8'h5A);

    exp_tx.push_back(8'h15);
    send_byte(8'h41);
    tx_latency("nak latency", 1);
    wait_tx_done();

    exp_tx.push_back(8'h15);
    send_byte(8'h52); send_byte(8'h10);
    tx_latency("range nak latency", 1);
    wait_tx_done();

    do_write(4'hF, 8'h00);

    // Timeout after a lone 'W'
    exp_to++;
    send_byte(8'h57);
    n = 0;
    while (!timeout && n < 200) begin @(negedge clk); n++; end
    chk("timeout cycle", n, 100);
    repeat (5) @(negedge clk);
    do_read(4'h1, 8'h58);

    // Backpressure: reply held in SEND while busy
    hold_busy = 1'b1;
    exp_wr.push_back({4'h2, 8'h33}); exp_tx.push_back(8'h06);
    send_byte(8'h57); send_byte(8'h02); send_byte(8'h33);
    n = 0;
    repeat (20) begin @(negedge clk); if (tx_en) n++; end
    chk("no tx_en while busy", n, 0);
    hold_busy = 1'b0;
    tx_latency("tx_en after busy falls", 1);
    wait_tx_done();

    // Overrun: byte during WAIT_DONE is dropped
    exp_ov++;
    exp_rd.push_back(4'h4); exp_tx.push_back(8'h5D);
    send_byte(8'h52); send_byte(8'h04);
    tx_latency("read latency", 3);
    send_byte(8'h52);
    wait_tx_done();
    repeat (10) @(negedge clk);
    do_write(4'h6, 8'h77);

    // Reset in GET_DATA
    send_byte(8'h57); send_byte(8'h01);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); check_zero("reset in GET_DATA");
    rst = 1'b0;
    do_write(4'h1, 8'h11);

    // Reset in WAIT_DONE
    exp_rd.push_back(4'h2); exp_tx.push_back(8'h5B);
    send_byte(8'h52); send_byte(8'h02);
    tx_latency("read latency", 3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); check_zero("reset in WAIT_DONE");
    rst = 1'b0;
    do_write(4'h1, 8'h11);

    repeat (5) @(negedge clk);
    chk("tx queue drained", exp_tx.size(), 0);
    chk("write queue drained", exp_wr.size(), 0);
    chk("read queue drained", exp_rd.size(), 0);
    chk("timeout pulses", seen_to, exp_to);
    chk("overrun pulses", seen_ov, exp_ov);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
